// File: rtl/bt_uart_pkg.sv
// bt_uart_pkg: shared types and helpers for the Bluetooth UART transmitter.
// Holds the framer state enum, line levels and the baud divisor function.
package bt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bt_uart_tx_if.sv
// bt_uart_tx_if: byte producer handshake (tx_data, tx_valid, tx_ready).
// master = producer side, slave = transmitter side.
interface bt_uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/bt_tx_fifo.sv
// bt_tx_fifo: synchronous byte FIFO, power-of-2 depth, async active-low reset.
// Ports: push/wr_data in, pop/rd_data (head) out, count/full/empty status.
module bt_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bt_uart_tx.sv
// bt_uart_tx: 8N1 UART transmitter with byte FIFO for the HC-05/06 RX pin.
// Ports: clk, rst_n, tx_if (slave handshake), SlaveTx, busy, fifo_count.
module bt_uart_tx
  import bt_uart_pkg::*;
#(
  parameter  int CLK_HZ     = 100_000_000,
  parameter  int BAUD       = 9600,
  parameter  int FIFO_DEPTH = 4,
  localparam int DIV        = calc_div(CLK_HZ, BAUD),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bt_uart_tx_if.slave   tx_if,
  output logic          SlaveTx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             line_q, line_d;
  logic             pend_q;
  logic             pop;
  logic             last;
  logic             full;
  logic             empty;
  logic [7:0]       head;

  bt_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_if.tx_valid),
    .wr_data (tx_if.tx_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign tx_if.tx_ready = !full;
  assign SlaveTx        = line_q;
  assign busy           = (state_q != IDLE) || (fifo_count != '0);
  assign last           = (cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= IDLE_LEVEL;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      pend_q  <= !empty;
    end
  end

  // Idle start waits on the registered non-empty flag: the line drops
  // two edges after the push. STOP chains straight into START.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        line_d = IDLE_LEVEL;
        if (pend_q) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          line_d  = START_LEVEL;
        end
      end
      START: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            line_d  = STOP_LEVEL;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            line_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            line_d  = START_LEVEL;
          end else begin
            state_d = IDLE;
            line_d  = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        line_d  = IDLE_LEVEL;
      end
    endcase
  end

endmodule
